mmio_input_port: RTL

- Memory-mapped input peripheral on the CPU data-memory bus; the read-side counterpart of the LED output decoder.
- Synchronises and debounces the board buttons and switches, and latches press/release events until software clears them.
- Sits beside dmem in the top wrapper. The wrapper muxes this block's read data onto the CPU data-in bus when SEL is high.

---
 rtl/mmio_input_port_pkg.sv | 13 +
 rtl/mmio_input_port_debounce_cell.sv | 56 +++++
 rtl/mmio_input_port.sv | 107 ++++++++++
 3 files changed

// File: rtl/mmio_input_port_pkg.sv
// Shared register map and defaults for the memory-mapped input port.
// The top level and its bench import these names.
package mmio_input_port_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0010;
  localparam int unsigned NUM_REGS          = 4;

  localparam logic [1:0] OFF_STATE   = 2'd0;
  localparam logic [1:0] OFF_PRESS   = 2'd1;
  localparam logic [1:0] OFF_RELEASE = 2'd2;
  localparam logic [1:0] OFF_IRQ_EN  = 2'd3;

endpackage

// File: rtl/mmio_input_port_debounce_cell.sv
// One input bit: two-flop synchroniser, stability counter and debounced state.
// The rise/fall pulses are asserted in the cycle before the edge on which state flips.
module mmio_input_port_debounce_cell #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic state_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            state_q, state_d;
  logic            flip;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    flip    = 1'b0;
    if (sync2_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      // Terminal count: accept the change and restart, so the counter never wraps.
      flip    = 1'b1;
      state_d = ~state_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign rise_o  = flip & ~state_q;
  assign fall_o  = flip & state_q;

endmodule

// File: rtl/mmio_input_port.sv
// Memory-mapped debounced button/switch port with W1C press/release latches
// and a level interrupt over enabled press events.
module mmio_input_port
  import mmio_input_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned N_SW            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             CLK100MHZ,
  input  logic             RST,
  input  logic [N_BTN-1:0] BTN_IN,
  input  logic [N_SW-1:0]  SW_IN,
  input  logic [31:0]      MEM_ACCESS_ADDRESS_BUS,
  input  logic             MEM_ACCESS_READ_WRN,
  input  logic [31:0]      MEM_ACCESS_DATA_OUT_BUS,
  output logic [31:0]      MEM_ACCESS_DATA_IN_BUS,
  output logic             SEL,
  output logic             IRQ
);

  localparam int unsigned NIn  = N_BTN + N_SW;
  localparam int unsigned OffW = $clog2(NUM_REGS);

  logic [NIn-1:0]  in_vec, state, rise, fall;
  logic [NIn-1:0]  press_q, press_d, release_q, release_d, irq_en_q, irq_en_d;
  logic [NIn-1:0]  wdata, rdata;
  logic            irq_q, irq_d;
  logic [31:0]     offset;
  logic [OffW-1:0] reg_sel;
  logic            wr_en;
  logic            unused_wdata;

  assign in_vec = {SW_IN, BTN_IN};

  for (genvar i = 0; i < NIn; i++) begin : g_cell
    mmio_input_port_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk_i  (CLK100MHZ),
      .rst_i  (RST),
      .in_i   (in_vec[i]),
      .state_o(state[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

  // Unsigned subtract: addresses below BASE_ADDR wrap high and miss the window.
  assign offset  = MEM_ACCESS_ADDRESS_BUS - BASE_ADDR;
  assign SEL     = (offset[31:OffW] == '0);
  assign reg_sel = offset[OffW-1:0];
  assign wr_en   = SEL & ~MEM_ACCESS_READ_WRN;

  assign wdata        = MEM_ACCESS_DATA_OUT_BUS[NIn-1:0];
  assign unused_wdata = ^MEM_ACCESS_DATA_OUT_BUS[31:NIn];

  always_comb begin
    press_d   = press_q;
    release_d = release_q;
    irq_en_d  = irq_en_q;
    if (wr_en) begin
      case (reg_sel)
        OFF_PRESS:   press_d   = press_q & ~wdata;
        OFF_RELEASE: release_d = release_q & ~wdata;
        OFF_IRQ_EN:  irq_en_d  = wdata;
        default:     ;
      endcase
    end
    // New events are OR-ed in after the clear so a same-edge set wins.
    press_d   = press_d | rise;
    release_d = release_d | fall;
    irq_d     = |(press_d & irq_en_d);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      press_q   <= '0;
      release_q <= '0;
      irq_en_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (SEL) begin
      case (reg_sel)
        OFF_STATE:   rdata = state;
        OFF_PRESS:   rdata = press_q;
        OFF_RELEASE: rdata = release_q;
        OFF_IRQ_EN:  rdata = irq_en_q;
        default:     rdata = '0;
      endcase
    end
  end

  assign MEM_ACCESS_DATA_IN_BUS = {{(32 - NIn){1'b0}}, rdata};
  assign IRQ                    = irq_q;

endmodule
